// File: rtl/instr_sequencer.sv
// Control sequencer for the single-cycle datapath: issues a fixed program of
// instruction indices with decoded write enables, holding each for HOLD_CYCLES
// cycles. The optional single-step mode is enabled by defining INSTR_SEQ_STEP_EN.
module instr_sequencer #(
  parameter int ADDR_W      = 3,
  parameter int NUM_INSTR   = 5,
  parameter int HOLD_CYCLES = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
`ifdef INSTR_SEQ_STEP_EN
  input  logic              step,
`endif
  output logic [ADDR_W-1:0] instruction_A,
  output logic              RegWrite,
  output logic              MemWrite,
  output logic              instr_valid,
  output logic              busy,
  output logic              done
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
`ifdef INSTR_SEQ_STEP_EN
  localparam logic [1:0] S_PAUSE = 2'd3;
`endif

  localparam logic [ADDR_W-1:0] LAST_INDEX = ADDR_W'(NUM_INSTR - 1);
  localparam logic [HOLD_W-1:0] LAST_HOLD  = HOLD_W'(HOLD_CYCLES - 1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] index;
  logic [HOLD_W-1:0] hold;

  // Write-enable decode for the fixed program: {RegWrite, MemWrite}.
  function automatic logic [1:0] decode(input logic [ADDR_W-1:0] idx);
    case (int'(idx))
      1:       decode = 2'b10;
      2:       decode = 2'b01;
      3, 4:    decode = 2'b10;
      default: decode = 2'b00;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      index <= '0;
      hold  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_ISSUE;
            index <= '0;
            hold  <= '0;
          end
        end
        S_ISSUE: begin
          if (!stall) begin
            if (hold == LAST_HOLD) begin
              hold <= '0;
              if (index == LAST_INDEX) begin
                state <= S_DONE;
              end else begin
`ifdef INSTR_SEQ_STEP_EN
                // Keep the completed index visible until the operator steps on.
                state <= S_PAUSE;
`else
                index <= index + 1'b1;
`endif
              end
            end else begin
              hold <= hold + 1'b1;
            end
          end
        end
`ifdef INSTR_SEQ_STEP_EN
        S_PAUSE: begin
          if (!stall && step) begin
            state <= S_ISSUE;
            index <= index + 1'b1;
            hold  <= '0;
          end
        end
`endif
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs come from state and counters; stall only masks valid and enables.
  always_comb begin
    instruction_A = '0;
    RegWrite      = 1'b0;
    MemWrite      = 1'b0;
    instr_valid   = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    case (state)
      S_ISSUE: begin
        busy          = 1'b1;
        instruction_A = index;
        if (!stall) begin
          instr_valid            = 1'b1;
          {RegWrite, MemWrite}   = decode(index);
        end
      end
`ifdef INSTR_SEQ_STEP_EN
      S_PAUSE: begin
        busy          = 1'b1;
        instruction_A = index;
      end
`endif
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: a reference model expands each run into
// its expected instruction stream and done cycle; a monitor checks the DUT against them.
module tb_instr_sequencer;

  localparam int ADDR_W      = 3;
  localparam int NUM_INSTR   = 5;
  localparam int HOLD_CYCLES = 10;
  localparam int RUN_LEN     = NUM_INSTR * HOLD_CYCLES;
`ifdef INSTR_SEQ_STEP_EN
  localparam int PAUSES = NUM_INSTR - 1;
`else
  localparam int PAUSES = 0;
`endif

  typedef struct {
    int idx;
    bit reg_write;
    bit mem_write;
  } exp_t;

  logic              clk;
  logic              rst;
  logic              start;
  logic              stall;
  logic [ADDR_W-1:0] instruction_A;
  logic              RegWrite;
  logic              MemWrite;
  logic              instr_valid;
  logic              busy;
  logic              done;
  logic [ADDR_W+4:0] outs;

  logic              s_start;
  logic [ADDR_W-1:0] s_instruction_A;
  logic              s_reg_write;
  logic              s_mem_write;
  logic              s_valid;
  logic              s_busy;
  logic              s_done;

  exp_t stream_q[$];
  int   done_q[$];
  exp_t mon_e;
  int   last_idx = 0;
  int   exp_idx;
  int   cycle_count = 0;
  int   busy_run = 0;
  int   checks = 0;
  int   passes = 0;
  int   e0;

  bit reg_table[8] = '{0, 1, 0, 1, 1, 0, 0, 0};
  bit mem_table[8] = '{0, 0, 1, 0, 0, 0, 0, 0};

  instr_sequencer #(.ADDR_W(ADDR_W), .NUM_INSTR(NUM_INSTR), .HOLD_CYCLES(HOLD_CYCLES)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .stall(stall),
`ifdef INSTR_SEQ_STEP_EN
    .step(1'b1),
`endif
    .instruction_A(instruction_A),
    .RegWrite(RegWrite),
    .MemWrite(MemWrite),
    .instr_valid(instr_valid),
    .busy(busy),
    .done(done)
  );

  instr_sequencer #(.ADDR_W(ADDR_W), .NUM_INSTR(1), .HOLD_CYCLES(1)) dut_small (
    .clk(clk),
    .rst(rst),
    .start(s_start),
    .stall(1'b0),
`ifdef INSTR_SEQ_STEP_EN
    .step(1'b1),
`endif
    .instruction_A(s_instruction_A),
    .RegWrite(s_reg_write),
    .MemWrite(s_mem_write),
    .instr_valid(s_valid),
    .busy(s_busy),
    .done(s_done)
  );

  assign outs = {instruction_A, RegWrite, MemWrite, instr_valid, busy, done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle_count <= cycle_count + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycle_count);
  endtask

  task automatic recordFail(input string name);
    checks++;
    $display("[TB] FAIL %s: event not expected by the model (cycle %0d)", name, cycle_count);
  endtask

  // Model: a run is NUM_INSTR instructions of HOLD_CYCLES valid cycles each,
  // with done landing after every ISSUE, PAUSE and stalled cycle has elapsed.
  function automatic void push_run(input int first_edge, input int extra);
    exp_t e;
    for (int i = 0; i < NUM_INSTR; i++) begin
      for (int h = 0; h < HOLD_CYCLES; h++) begin
        e.idx       = i;
        e.reg_write = reg_table[i];
        e.mem_write = mem_table[i];
        stream_q.push_back(e);
      end
    end
    done_q.push_back(first_edge + RUN_LEN + PAUSES + extra);
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      if (instr_valid) begin
        if (stream_q.size() == 0) recordFail("unexpected_valid");
        else begin
          mon_e = stream_q.pop_front();
          checkOutput("issue_stream", 32'({instruction_A, RegWrite, MemWrite}),
                      32'({mon_e.idx[ADDR_W-1:0], mon_e.reg_write, mon_e.mem_write}));
          last_idx = mon_e.idx;
        end
      end
      if (stall && busy) begin
        exp_idx = (stream_q.size() != 0) ? stream_q[0].idx : last_idx;
`ifdef INSTR_SEQ_STEP_EN
        if (int'(instruction_A) == last_idx) exp_idx = last_idx;
`endif
        checkOutput("stall_freeze", 32'({instr_valid, RegWrite, MemWrite, instruction_A}), 32'(exp_idx));
      end
      if (done) begin
        if (done_q.size() == 0) recordFail("unexpected_done");
        else checkOutput("done_cycle", 32'(cycle_count), 32'(done_q.pop_front()));
        checkOutput("done_quiet", 32'({busy, instr_valid}), 32'd0);
      end
      if (busy) busy_run++;
    end
  end

  task automatic waitDone(input int budget, input int remaining);
    int n = 0;
    while (done_q.size() > remaining && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (done_q.size() > remaining) begin
      recordFail("done_timeout");
      done_q.delete();
      stream_q.delete();
    end
  endtask

  // One run, optionally stalled for stall_len cycles from ISSUE cycle stall_at,
  // with start optionally raised during the stall to show it is ignored.
  task automatic applyStimulus(input int stall_at, input int stall_len, input bit noise);
    int first_edge;
    @(posedge clk); #1;
    start = 1'b1;
    first_edge = cycle_count + 1;
    push_run(first_edge, stall_len);
    busy_run = 0;
    @(posedge clk); #1;
    start = 1'b0;
    if (stall_len > 0) begin
      repeat (stall_at) @(posedge clk);
      #1;
      stall = 1'b1;
      start = noise;
      repeat (stall_len) @(posedge clk);
      #1;
      stall = 1'b0;
      start = 1'b0;
    end
    waitDone(RUN_LEN + PAUSES + stall_len + 20, 0);
    checkOutput("busy_cycles", 32'(busy_run), 32'(RUN_LEN + PAUSES + stall_len));
    @(negedge clk);
    checkOutput("idle_after_done", 32'(outs), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    stall = 1'b0;
    s_start = 1'b0;
    #1 rst = 1'b0;
    start = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checkOutput("reset_outputs", 32'(outs), 32'd0);
    end
    checkOutput("small_reset", 32'({s_instruction_A, s_reg_write, s_mem_write, s_valid, s_busy, s_done}), 32'd0);

    $display("[TB] full run after reset release");
    @(posedge clk); #3;
    rst = 1'b1;
    e0 = cycle_count + 1;
    push_run(e0, 0);
    busy_run = 0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    checkOutput("first_issue", 32'({busy, instruction_A}), 32'({1'b1, 3'd0}));
    waitDone(RUN_LEN + PAUSES + 20, 0);
    checkOutput("busy_cycles", 32'(busy_run), 32'(RUN_LEN + PAUSES));

    $display("[TB] stall during index 2");
    applyStimulus(24, 7, 1'b0);

    $display("[TB] async reset mid-run");
    @(posedge clk); #1;
    start = 1'b1;
    e0 = cycle_count + 1;
    push_run(e0, 0);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (35) @(posedge clk);
    #3 rst = 1'b0;
    #1 checkOutput("async_reset", 32'(outs), 32'd0);
    stream_q.delete();
    done_q.delete();
    repeat (3) begin
      @(negedge clk);
      checkOutput("reset_hold", 32'(outs), 32'd0);
    end
    @(posedge clk); #3 rst = 1'b1;
    applyStimulus(0, 0, 1'b0);

    $display("[TB] start held high for back-to-back runs");
    @(posedge clk); #1;
    start = 1'b1;
    e0 = cycle_count + 1;
    push_run(e0, 0);
    push_run(e0 + RUN_LEN + PAUSES + 2, 0);
    waitDone(RUN_LEN + PAUSES + 20, 1);
    @(posedge clk); #1;
    start = 1'b0;
    waitDone(RUN_LEN + PAUSES + 20, 0);
    @(negedge clk);
    checkOutput("idle_after_runs", 32'(outs), 32'd0);

    $display("[TB] randomized stalls and stray starts");
    for (int r = 0; r < 4; r++) begin
      applyStimulus(int'($urandom_range(1, RUN_LEN - 2)), int'($urandom_range(1, 8)),
                    1'($urandom_range(0, 1)));
    end

    $display("[TB] single instruction, single hold cycle");
    @(posedge clk); #1 s_start = 1'b1;
    @(posedge clk); #1 s_start = 1'b0;
    @(negedge clk);
    checkOutput("small_issue", 32'({s_busy, s_valid, s_instruction_A, s_reg_write, s_mem_write, s_done}),
                32'({1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0}));
    @(negedge clk);
    checkOutput("small_done", 32'({s_busy, s_valid, s_done}), 32'({1'b0, 1'b0, 1'b1}));
    @(negedge clk);
    checkOutput("small_idle", 32'({s_instruction_A, s_reg_write, s_mem_write, s_valid, s_busy, s_done}), 32'd0);

    checkOutput("stream_drained", 32'(stream_q.size()), 32'd0);
    checkOutput("done_drained", 32'(done_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Upstream control sequencer for the single-cycle datapath (`PC` top).
- Steps through a fixed program of instruction addresses and drives instruction_A, RegWrite and MemWrite.
- Holds each instruction for a programmable number of cycles, so the datapath completes before the next instruction is issued.
- Replaces hand-driven stimulus with a start/busy/done handshake and a stall input.

Parameters:
- ADDR_W, 3: width of instruction_A.
- NUM_INSTR, 5: number of instructions issued per run. Legal range 1..2**ADDR_W.
- HOLD_CYCLES, 10: clock cycles each instruction is held. Legal range ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  level; sampled only in IDLE, begins a run.
- stall  in  1  freezes the sequencer while high.
- instruction_A  out  ADDR_W  current instruction index to datapath.
- RegWrite  out  1  register-file write enable for current instruction.
- MemWrite  out  1  data-memory write enable for current instruction.
- instr_valid  out  1  instruction_A/enables are meaningful.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at end of run.

Behaviour:
- Reset: rst low asynchronously forces IDLE. All outputs go to 0, the index counter to 0 and the hold counter to 0. This also applies when rst falls mid-run. There is no partial completion and no done pulse.
- States: IDLE, ISSUE, DONE.
- IDLE:
  - All outputs 0.
  - start=1 at a rising edge → ISSUE, with index=0 and hold=0.
  - start=0 → stay in IDLE.
- ISSUE:
  - busy=1 and instr_valid=1 (0 while stall=1).
  - instruction_A=index.
  - Enables come from the decode table below and are forced to 0 while stall=1.
- Decode table (index: RegWrite, MemWrite):
  - 0: 0,0
  - 1: 1,0
  - 2: 0,1
  - 3: 1,0
  - 4: 1,0
  - 5–7: 0,0
- Hold counting:
  - Each unstalled cycle increments hold.
  - When hold==HOLD_CYCLES-1 on an unstalled cycle:
    - If index==NUM_INSTR-1 → DONE.
    - Otherwise index+1 and hold=0.
- Stall:
  - Index and hold are frozen; instruction_A keeps its value.
  - Stall on the final hold cycle of the last instruction blocks the DONE transition.
- DONE:
  - Lasts exactly one cycle: done=1, busy=0, instr_valid=0, enables 0.
  - Unconditionally → IDLE.
- Restart: start still high in IDLE the cycle after DONE begins a new run. Back-to-back runs have exactly one DONE and one IDLE cycle between them.
- start while in ISSUE or DONE is ignored.
- Latency:
  - Start sampled at edge E0 → instruction 0 visible after E0.
  - An unstalled run occupies NUM_INSTR*HOLD_CYCLES cycles of ISSUE. done asserts in the following cycle.
- Widths:
  - Index counter is ADDR_W bits and never wraps, because NUM_INSTR ≤ 2**ADDR_W.
  - Hold counter is $clog2(HOLD_CYCLES+1) bits.
  - HOLD_CYCLES=1 advances every unstalled cycle.
- Outputs are registered (driven from state/counters only). There is no combinational path from start or stall except the stall masking of enables and instr_valid.

Optional Feature:
- Macro INSTR_SEQ_STEP_EN.
- When defined:
  - Adds input port step (1 bit) and a PAUSE state.
  - After each instruction's final hold cycle (except the last), go to PAUSE instead of advancing.
  - PAUSE: busy=1, instr_valid=0, enables 0, instruction_A holds the completed index.
  - step=1 at an edge → ISSUE with index+1 and hold=0.
  - Reset in PAUSE → IDLE.
- When undefined: no step port, no PAUSE state, continuous sequencing as above.

Test Plan:
- Reset: hold rst=0 for 5 cycles with start=1 → all outputs 0. Release rst; the first rising edge with start=1 → instruction_A=0, busy=1 on the next cycle.
- Full run with defaults, no stall:
  - Instruction_A follows 0,1,2,3,4, each for 10 cycles.
  - RegWrite high only during indices 1,3,4. MemWrite high only during index 2.
  - busy high for 50 cycles; done pulses once at cycle 51; then IDLE.
- Stall:
  - stall=1 for 7 cycles starting at hold=4 of index 2 → MemWrite and instr_valid 0 during stall, instruction_A stays 2.
  - Index 2 lasts 17 cycles total; done is delayed by 7 cycles.
- Async reset mid-run: rst=0 at index 3, hold 5, asserted between clock edges → outputs 0 immediately with no done pulse. A new start restarts at index 0.
- Boundaries:
  - NUM_INSTR=1, HOLD_CYCLES=1: one cycle of instruction_A=0, then done.
  - start held high continuously gives runs separated by exactly 2 cycles (DONE, IDLE).
  - start asserted mid-run has no effect.
- With INSTR_SEQ_STEP_EN: after index 0's 10 cycles, sequencer waits in PAUSE (busy=1, instr_valid=0) for 20 cycles until step=1, then issues index 1. There is no PAUSE after index 4; done follows directly.
